spi_master_param: RTL and testbench

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

---
 rtl/spi_master_param_if.sv | 31 +++
 rtl/spi_master_param.sv | 109 ++++++++++
 tb/tb_spi_master_param.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_param_if.sv
// Bus bundle for spi_master_param: host request/response and the SPI pins.
// The master modport is the controller's view; slave is the host/pin side.
interface spi_master_param_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 2
);
  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [SS_W-1:0]   ss_sel;
  logic              cpol;
  logic              cpha;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic [NUM_SS-1:0] ss_n;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  modport master (
    input  start, tx_data, ss_sel, cpol, cpha, miso,
    output sclk, mosi, ss_n, busy, done, rx_data
  );

  modport slave (
    output start, tx_data, ss_sel, cpol, cpha, miso,
    input  sclk, mosi, ss_n, busy, done, rx_data
  );
endinterface

// File: rtl/spi_master_param.sv
// Full-duplex SPI master, MSB first, runtime-selectable CPOL/CPHA.
// Frame: LEAD and TRAIL guard phases of CLK_DIV cycles around 2*DATA_W SCLK edges.
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 2,
  parameter int CLK_DIV = 2
) (
  input logic               clk,
  input logic               rst,
  spi_master_param_if.master bus
);
  localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_data_q;
  logic [SS_W-1:0]   ss_q;
  logic              cpol_q, cpha_q, sclk_q, mosi_q, done_q;
  logic [NUM_SS-1:0] ss_n;
  logic              tick, last_edge, accept;

  assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_edge = (edge_cnt == EDGE_W'(2 * DATA_W - 1));
  assign accept    = (state == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start)        state_nxt = LEAD;
      LEAD:  if (tick)             state_nxt = XFER;
      XFER:  if (tick && last_edge) state_nxt = TRAIL;
      TRAIL: if (tick)             state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt   <= '0;
      edge_cnt  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data_q <= '0;
      ss_q      <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + DIV_W'(1);

      if (accept) begin
        cpol_q   <= bus.cpol;
        cpha_q   <= bus.cpha;
        ss_q     <= bus.ss_sel;
        sclk_q   <= bus.cpol;
        mosi_q   <= bus.tx_data[DATA_W-1];
        // CPHA=1 re-presents the MSB on the first leading edge, so keep it in the register.
        tx_sr    <= bus.cpha ? bus.tx_data : (bus.tx_data << 1);
        rx_sr    <= '0;
        edge_cnt <= '0;
      end

      if (state == XFER && tick) begin
        sclk_q   <= ~sclk_q;
        edge_cnt <= edge_cnt + EDGE_W'(1);
        // Even edge index = leading edge; sample on leading when cpha=0, trailing when cpha=1.
        if (edge_cnt[0] == cpha_q) begin
          rx_sr <= {rx_sr[DATA_W-2:0], bus.miso};
        end else if (!last_edge) begin
          mosi_q <= tx_sr[DATA_W-1];
          tx_sr  <= tx_sr << 1;
        end
      end

      if (state == TRAIL && tick) begin
        done_q    <= 1'b1;
        rx_data_q <= rx_sr;
      end
    end
  end

  // An out-of-range ss_q matches no line, so all selects stay high.
  always_comb begin
    ss_n = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (state != IDLE && ss_q == SS_W'(i)) ss_n[i] = 1'b0;
  end

  assign bus.ss_n    = ss_n;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = (state != IDLE) && mosi_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: vector table plus corner sequences, checked against
// a protocol-level SPI slave model and frame timing derived from the width/divider.
module tb_spi_master_param;
  localparam int DW  = 8;
  localparam int NS  = 2;
  localparam int CD  = 2;
  localparam int LAT = 1 + CD * (2 * DW + 2);

  typedef struct {
    logic [DW-1:0] tx;
    logic [1:0]    sel;
    logic          cpol, cpha, loopb;
    logic [DW-1:0] sword;
    logic [DW-1:0] exp_rx;
    logic [NS-1:0] exp_ssn;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_master_param_if #(.DATA_W(DW), .NUM_SS(NS)) bus ();
  spi_master_param_if #(.DATA_W(DW), .NUM_SS(3))  bus3 ();

  spi_master_param #(.DATA_W(DW), .NUM_SS(NS), .CLK_DIV(CD)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  spi_master_param #(.DATA_W(DW), .NUM_SS(3),  .CLK_DIV(CD)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Behavioural SPI slave: shifts s_word out MSB first, captures mosi into s_cap.
  logic          s_cpol = 1'b0, s_cpha = 1'b0, s_loop = 1'b0, s_miso = 1'b0;
  logic [DW-1:0] s_word = '0, s_cap = '0;
  int            s_idx = 0, e_cnt = 0;
  logic          prev_act = 1'b0, prev_sclk = 1'b0, act, lead;

  assign act      = (bus.ss_n != '1);
  assign bus.miso = s_loop ? bus.mosi : s_miso;

  always @(negedge clk) begin
    if (act && !prev_act) begin
      s_idx  = DW - 1;
      s_cap  = '0;
      e_cnt  = 0;
      s_miso = s_cpha ? 1'b0 : s_word[DW-1];
    end else if (act && bus.sclk != prev_sclk) begin
      e_cnt++;
      lead = (prev_sclk == s_cpol);
      if (lead ^ s_cpha) s_cap = {s_cap[DW-2:0], bus.mosi};
      else if (s_cpha) begin
        if (s_idx >= 0) s_miso = s_word[s_idx];
        s_idx--;
      end else begin
        s_idx--;
        if (s_idx >= 0) s_miso = s_word[s_idx];
      end
    end
    prev_act  = act;
    prev_sclk = bus.sclk;
  end

  task automatic launch(input vec_t v);
    s_cpol = v.cpol; s_cpha = v.cpha; s_loop = v.loopb; s_word = v.sword;
    bus.tx_data = v.tx; bus.ss_sel = v.sel[0:0];
    bus.cpol = v.cpol; bus.cpha = v.cpha; bus.start = 1'b1;
  endtask

  // Count cycles from acceptance to done; flag bad selects or rx_data moving early.
  task automatic wait_done(input logic [NS-1:0] exp_ssn, input bit hold, input int poke,
                           output int n, output bit ssbad, output bit holdbad);
    logic [DW-1:0] rx0;
    rx0 = bus.rx_data; n = 0; ssbad = 0; holdbad = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1 && !hold) bus.start = 1'b0;
      if (poke > 0 && n == poke) bus.start = 1'b1;
      if (poke > 0 && n == poke + 1) bus.start = 1'b0;
      if (!bus.done) begin
        if (bus.ss_n !== exp_ssn || !bus.busy) ssbad = 1;
        if (bus.rx_data !== rx0) holdbad = 1;
      end
    end while (!bus.done && n < LAT + 20);
  endtask

  task automatic post_check(input string nm, input vec_t v, input int n, input bit sb, input bit hb);
    chk({nm, "_latency"}, 32'(n), 32'(LAT));
    chk({nm, "_rx"}, 32'(bus.rx_data), 32'(v.exp_rx));
    chk({nm, "_slave_cap"}, 32'(s_cap), 32'(v.tx));
    chk({nm, "_edges"}, 32'(e_cnt), 32'(2 * DW));
    chk({nm, "_ss_during"}, 32'(sb), 32'd0);
    chk({nm, "_rx_hold"}, 32'(hb), 32'd0);
    chk({nm, "_done_cycle"}, 32'({bus.ss_n, bus.busy, bus.sclk, bus.mosi}),
        32'({2'b11, 1'b0, v.cpol, 1'b0}));
  endtask

  task automatic run_vec(input string nm, input vec_t v, input int poke);
    int n; bit sb, hb;
    launch(v);
    wait_done(v.exp_ssn, 1'b0, poke, n, sb, hb);
    post_check(nm, v, n, sb, hb);
  endtask

  vec_t vecs[8];

  initial begin
    int n, dn, k;
    bit sb, hb, bad3;
    vec_t va, vb;

    vecs[0] = '{tx: 8'hA5, sel: 2'd0, cpol: 0, cpha: 0, loopb: 1, sword: 8'h00, exp_rx: 8'hA5, exp_ssn: 2'b10};
    vecs[1] = '{tx: 8'h81, sel: 2'd0, cpol: 1, cpha: 1, loopb: 0, sword: 8'h3C, exp_rx: 8'h3C, exp_ssn: 2'b10};
    vecs[2] = '{tx: 8'h5A, sel: 2'd1, cpol: 0, cpha: 1, loopb: 0, sword: 8'hC3, exp_rx: 8'hC3, exp_ssn: 2'b01};
    for (int i = 3; i < 8; i++) begin
      vecs[i].tx    = 8'($urandom);
      vecs[i].sword = 8'($urandom);
      vecs[i].sel   = 2'($urandom_range(0, 1));
      vecs[i].cpol  = 1'($urandom_range(0, 1));
      vecs[i].cpha  = 1'($urandom_range(0, 1));
      vecs[i].loopb = 1'b0;
      vecs[i].exp_rx  = vecs[i].sword;
      vecs[i].exp_ssn = 2'(~(2'b01 << vecs[i].sel));
    end

    bus.start = 0; bus.tx_data = '0; bus.ss_sel = '0; bus.cpol = 0; bus.cpha = 0;
    bus3.start = 0; bus3.tx_data = '0; bus3.ss_sel = '0; bus3.cpol = 0; bus3.cpha = 0; bus3.miso = 0;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", 32'(bus.ss_n), 32'h3);
    chk("rst_sclk", 32'(bus.sclk), 32'h0);
    chk("rst_mosi", 32'(bus.mosi), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_rx", 32'(bus.rx_data), 32'h0);
    chk("rst_ss_n3", 32'(bus3.ss_n), 32'h7);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i], 0);

    // start pulsed mid-transfer must be dropped, not queued.
    run_vec("ignore_start", vecs[1], 10);
    dn = 0;
    repeat (LAT + 5) begin @(negedge clk); dn += int'(bus.done); end
    chk("ignore_start_extra_done", 32'(dn), 32'd0);
    chk("ignore_start_busy", 32'(bus.busy), 32'd0);

    // Reset after 5 SCLK edges aborts cleanly.
    va = '{tx: 8'hF0, sel: 2'd1, cpol: 1, cpha: 0, loopb: 0, sword: 8'h12, exp_rx: 8'h12, exp_ssn: 2'b01};
    launch(va);
    k = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      k++;
    end while (!(act && e_cnt == 5) && k < 100);
    chk("abort_reach_edge5", 32'(k < 100), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_ss_n", 32'(bus.ss_n), 32'h3);
    chk("abort_sclk", 32'(bus.sclk), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    chk("abort_rx", 32'(bus.rx_data), 32'h0);
    dn = 0;
    repeat (LAT + 5) begin @(negedge clk); dn += int'(bus.done); end
    chk("abort_no_done", 32'(dn), 32'd0);
    chk("abort_sclk_idle", 32'(bus.sclk), 32'h0);

    // Out-of-range select on the three-line instance: no select, normal timing.
    bus3.tx_data = 8'h3C; bus3.ss_sel = 2'd3; bus3.start = 1'b1;
    n = 0; bad3 = 0;
    do begin
      @(negedge clk);
      n++;
      bus3.start = 1'b0;
      if (bus3.ss_n !== 3'b111) bad3 = 1;
    end while (!bus3.done && n < LAT + 20);
    chk("oor_latency", 32'(n), 32'(LAT));
    chk("oor_ss_n_high", 32'(bad3), 32'd0);

    // Back-to-back: start held through done, mode 1 then mode 2.
    va = '{tx: 8'h6B, sel: 2'd0, cpol: 0, cpha: 1, loopb: 0, sword: 8'hD4, exp_rx: 8'hD4, exp_ssn: 2'b10};
    vb = '{tx: 8'h29, sel: 2'd1, cpol: 1, cpha: 0, loopb: 0, sword: 8'h97, exp_rx: 8'h97, exp_ssn: 2'b01};
    launch(va);
    wait_done(va.exp_ssn, 1'b1, 0, n, sb, hb);
    post_check("b2b_first", va, n, sb, hb);
    launch(vb);
    wait_done(vb.exp_ssn, 1'b0, 0, n, sb, hb);
    post_check("b2b_second", vb, n, sb, hb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
